// File: rtl/seq_cla_subtractor.sv
// seq_cla_subtractor: multi-cycle WIDTH-bit subtractor, Diff = A - B - Bin.
// One SLICE-bit slice per clock, LSB first, with borrow-lookahead inside
// each slice and the slice borrow carried between cycles in a register.
// Optional macro SUB_ZERO_BYPASS_EN: B=0 and Bin=0 completes in one cycle
// without entering RUN.
// WIDTH must be an integer multiple of SLICE with at least two slices.
module seq_cla_subtractor #(
  parameter int WIDTH = 20,
  parameter int SLICE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_reg, state_next;
  logic   accept, finish, bypass;

  logic [WIDTH-1:0]       a_sh_reg, b_sh_reg;
  logic                   borrow_reg;
  logic                   a_msb_reg, b_msb_reg;
  logic [CW-1:0]          cnt_reg;
  logic [WIDTH-SLICE-1:0] acc_reg;

  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg, ovf_reg, done_reg;

  logic [SLICE-1:0] sa, sb, p, g, sd;
  logic [SLICE:0]   bc;
  logic [WIDTH-1:0] full_diff;

  // Flattened lookahead borrow into bit position top+1 of a slice:
  // OR over every generate term g[j] that propagates through p[j+1..top],
  // plus the slice borrow-in propagated through p[0..top].
  function automatic logic borrow_at(input logic [SLICE-1:0] pv,
                                     input logic [SLICE-1:0] gv,
                                     input logic             cin,
                                     input int               top);
    logic acc, path;
    acc = cin;
    for (int k = 0; k <= top; k++) acc = acc & pv[k];
    for (int j = 0; j <= top; j++) begin
      path = gv[j];
      for (int k = j + 1; k <= top; k++) path = path & pv[k];
      acc = acc | path;
    end
    return acc;
  endfunction

  // Current slice is always the low SLICE bits of the shift registers.
  assign sa    = a_sh_reg[SLICE-1:0];
  assign sb    = b_sh_reg[SLICE-1:0];
  assign bc[0] = borrow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_bit
      assign p[gi]    = ~(sa[gi] ^ sb[gi]);
      assign g[gi]    = ~sa[gi] & sb[gi];
      assign bc[gi+1] = borrow_at(p, g, borrow_reg, gi);
      assign sd[gi]   = sa[gi] ^ sb[gi] ^ bc[gi];
    end
  endgenerate

  // New slice goes on top; earlier slices sit below it, LSB slice lowest.
  assign full_diff = {sd, acc_reg};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    bypass     = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef SUB_ZERO_BYPASS_EN
          if ((B == '0) && !Bin) begin
            bypass = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = RUN;
          end
`else
          accept     = 1'b1;
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == CW'(NSLICES - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, slice shifting, inter-slice borrow and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      borrow_reg <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
    end else if (accept) begin
      a_sh_reg   <= A;
      b_sh_reg   <= B;
      borrow_reg <= Bin;
      a_msb_reg  <= A[WIDTH-1];
      b_msb_reg  <= B[WIDTH-1];
      cnt_reg    <= '0;
      acc_reg    <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> SLICE;
      b_sh_reg   <= b_sh_reg >> SLICE;
      borrow_reg <= bc[SLICE];
      cnt_reg    <= cnt_reg + CW'(1);
      acc_reg    <= full_diff[WIDTH-1:SLICE];
    end
  end

  // Result registers: only written at completion so no partial value leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= finish | bypass;
      if (finish) begin
        diff_reg       <= full_diff;
        borrow_out_reg <= bc[SLICE];
        ovf_reg        <= (a_msb_reg != b_msb_reg) &&
                          (full_diff[WIDTH-1] != a_msb_reg);
      end else if (bypass) begin
        diff_reg       <= A;
        borrow_out_reg <= 1'b0;
        ovf_reg        <= 1'b0;
      end
    end
  end

  assign done     = done_reg;
  assign Diff     = diff_reg;
  assign Borrow   = borrow_out_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// tb_seq_cla_subtractor: table vectors, hand sequences for busy-start,
// back-to-back and mid-run reset, then random operands against an
// arithmetic reference model.
module tb_seq_cla_subtractor;

  localparam int W  = 20;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst, start, Bin;
  logic [W-1:0]  A, B;
  logic          ready, busy, done, Borrow, Overflow;
  logic [W-1:0]  Diff;

  int n_cmp = 0;
  int n_bad = 0;

  seq_cla_subtractor dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .ready(ready), .busy(busy), .done(done), .Diff(Diff),
    .Borrow(Borrow), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    longint r;
    r  = longint'(a) - longint'(b) - longint'(bin);
    d  = r[W-1:0];
    bo = (r < 0);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // Called at a falling edge. Presents one op, waits for done, checks it.
  // lat counts clock edges after the accepting edge up to the edge that
  // raises done. flood pulses start with junk operands while waiting.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic ebo, input logic eov,
                        input bit flood, input string tag);
    int          cyc, exp_lat;
    bit          seen_busy, held, exp_busy;
    logic [21:0] prev;
    exp_lat  = NS;
    exp_busy = 1'b1;
`ifdef SUB_ZERO_BYPASS_EN
    if (b == '0 && bin == 1'b0) begin
      exp_lat  = 0;
      exp_busy = 1'b0;
    end
`endif
    prev = {Diff, Borrow, Overflow};
    chk({tag, " ready_before"}, ready, 1);
    start = 1'b1; A = a; B = b; Bin = bin;
    cyc = 0; seen_busy = 1'b0; held = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy) seen_busy = 1'b1;
      if (done) break;
      if ({Diff, Borrow, Overflow} != prev) held = 1'b0;
      if (cyc >= 20) break;
      if (flood) begin
        start = 1'b1; A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " latency"}, cyc - 1, exp_lat);
    chk({tag, " Diff"}, Diff, ed);
    chk({tag, " Borrow"}, Borrow, ebo);
    chk({tag, " Overflow"}, Overflow, eov);
    chk({tag, " outputs_held"}, held, 1);
    chk({tag, " busy_seen"}, seen_busy, exp_busy);
    chk({tag, " ready_at_done"}, ready, 1);
    $display("op %s A=%05h B=%05h Bin=%0d -> Diff=%05h Borrow=%0d Overflow=%0d lat=%0d",
             tag, a, b, bin, Diff, Borrow, Overflow, cyc - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb, ed;
    logic         rbin, ebo, eov;

    vecs[0] = '{20'h00005, 20'h00003, 1'b0, 20'h00002, 1'b0, 1'b0};
    vecs[1] = '{20'h00000, 20'h00001, 1'b0, 20'hFFFFF, 1'b1, 1'b0};
    vecs[2] = '{20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 1'b0, 1'b1};
    vecs[3] = '{20'h00020, 20'h00001, 1'b0, 20'h0001F, 1'b0, 1'b0};
    vecs[4] = '{20'h12345, 20'h02345, 1'b1, 20'h0FFFF, 1'b0, 1'b0};
    vecs[5] = '{20'hABCDE, 20'h00000, 1'b0, 20'hABCDE, 1'b0, 1'b0};
    vecs[6] = '{20'h7FFFF, 20'hFFFFF, 1'b0, 20'h80000, 1'b1, 1'b1};
    vecs[7] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0};
    vecs[8] = '{20'h00000, 20'h00000, 1'b1, 20'hFFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset Diff", Diff, 0);
    chk("reset Borrow", Borrow, 0);
    chk("reset Overflow", Overflow, 0);

    // Table vectors, issued back to back.
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov,
             1'b0, $sformatf("vec%0d", i));
    @(negedge clk);
    chk("done_single_pulse", done, 0);

    // Start hammered during RUN is ignored; start in the done cycle is taken.
    run_op(20'h00005, 20'h00003, 1'b0, 20'h00002, 1'b0, 1'b0, 1'b1, "flood");
    run_op(20'h12345, 20'h02345, 1'b1, 20'h0FFFF, 1'b0, 1'b0, 1'b0, "in_done");

    // Reset while slice 2 is being computed.
    run_op(20'h7FFFF, 20'hFFFFF, 1'b0, 20'h80000, 1'b1, 1'b1, 1'b0, "pre_rst");
    start = 1'b1; A = 20'h54321; B = 20'h12345; Bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst done", done, 0);
    chk("mid_rst Diff", Diff, 0);
    chk("mid_rst Borrow", Borrow, 0);
    chk("mid_rst Overflow", Overflow, 0);
    chk("mid_rst ready", ready, 1);
    chk("mid_rst busy", busy, 0);
    run_op(20'h00020, 20'h00001, 1'b0, 20'h0001F, 1'b0, 1'b0, 1'b0, "post_rst");

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i % 8 == 3) begin
        rb = '0; rbin = 1'b0;
      end
      model(ra, rb, rbin, ed, ebo, eov);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      run_op(ra, rb, rbin, ed, ebo, eov, 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_cla_subtractor.md
Name: seq_cla_subtractor

Overview:
- Multi-cycle 20-bit subtractor computing Diff = A - B - Bin.
- Processes one 5-bit slice per clock, LSB slice first, using 5-bit borrow-lookahead logic inside each slice.
- Start/done handshake; sits beside the 20-bit adder datapath as its low-area subtract path.

Parameters:
WIDTH, 20, operand/result width; must be an integer multiple of SLICE
SLICE, 5, bits processed per clock; borrow-lookahead span
NSLICES, WIDTH/SLICE (4), derived localparam, not overridable

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when ready=1
A  input  WIDTH  minuend, captured on accepted start
B  input  WIDTH  subtrahend, captured on accepted start
Bin  input  1  borrow-in, captured on accepted start
ready  output  1  high in IDLE; start accepted only when high
busy  output  1  high in RUN
done  output  1  one-cycle pulse; results valid from this cycle onward
Diff  output  WIDTH  difference, held until next completion
Borrow  output  1  final borrow-out (1 when unsigned A < B+Bin), held
Overflow  output  1  two's-complement overflow, held

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ready=1, busy=0, done=0, Diff=0, Borrow=0, Overflow=0. Slice counter and internal operand registers are cleared.
- States are IDLE and RUN.
  - IDLE: if start=1, latch A, B and Bin into shift registers, set the slice counter to 0, go to RUN.
  - RUN: each cycle compute slice k = counter.
    - Per bit: p = ~(a^b), g = ~a&b.
    - Slice borrow chain (lookahead): b(i+1) = g(i) | p(i)&b(i).
    - Result bit: d = a^b^b(i).
  - The slice borrow-out is registered into the next slice's borrow-in.
  - The partial result shifts into an internal accumulator.
  - When counter = NSLICES-1, go to IDLE. On that edge, load Diff from the accumulator plus the final slice, load Borrow and Overflow, and set done=1 for exactly one cycle.
- Latency: start accepted at edge t; done=1 during the cycle after edge t+NSLICES, i.e. 4 cycles.
- Outputs:
  - Diff, Borrow and Overflow update only at completion and never show partial values.
  - Overflow = (A[MSB] != B[MSB]) & (Diff[MSB] != A[MSB]), using the latched operands.
- start while busy=1 is ignored: no effect on the operation in flight and no queuing.
- start in the done cycle: ready is already 1, so it is accepted and back-to-back throughput is NSLICES cycles per op.
- A, B and Bin may change freely after acceptance.
- rst mid-RUN: the operation is discarded, done is not pulsed, outputs go to reset values, and ready=1 on the next cycle.
- Wrap-around: the result is modulo 2^WIDTH; e.g. 0 - 1 = all ones with Borrow=1.

Optional Feature:
- Macro: SUB_ZERO_BYPASS_EN.
- Defined: on an accepted start with B=0 and Bin=0, skip RUN.
  - Next edge: Diff=A, Borrow=0, Overflow=0, done=1.
  - State stays IDLE, so latency is 1 cycle.
  - busy stays 0 throughout.
- Undefined: no bypass; every operation takes NSLICES cycles through RUN.

Test Plan:
1. A=0x00005, B=0x00003, Bin=0 -> done exactly 4 cycles after start; Diff=0x00002, Borrow=0, Overflow=0.
2. A=0x00000, B=0x00001, Bin=0 -> Diff=0xFFFFF, Borrow=1, Overflow=0. Then A=0x80000, B=0x00001 -> Diff=0x7FFFF, Borrow=0, Overflow=1.
3. Inter-slice borrow: A=0x00020, B=0x00001 -> Diff=0x0001F. Then A=0x12345, B=0x02345, Bin=1 -> Diff=0x0FFFF, Borrow=0.
4. start pulsed on each cycle of RUN with other operands -> ignored; first result correct; a new start in the done cycle is accepted and its done follows 4 cycles later.
5. rst asserted during slice 2 -> no done pulse; Diff=0, Borrow=0, Overflow=0, ready=1 the next cycle. A subsequent op completes correctly.
6. With SUB_ZERO_BYPASS_EN: A=0xABCDE, B=0, Bin=0 -> done the next cycle, Diff=0xABCDE, busy never 1. Without the macro -> same result after 4 cycles.
